// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared state encoding and default sizing for the core memory port controller.
package core_mem_pkg;
  localparam int PORTS = 4;
  localparam int ADDR_W_DEF = 14;
  localparam int WORD_W_DEF = 36;
  localparam int T_RD_DEF = 4;
  localparam int T_WR_DEF = 4;
  typedef enum logic [2:0] {S_IDLE, S_ACK, S_RD, S_RS_WAIT, S_WR, S_REST} state_t;
endpackage

// File: rtl/core_mem_port_arb.sv
// core_mem_port_arb: one-hot grant selection among the four memory ports.
// CORE_MEM_RR_ARB_EN selects round-robin (pointer resets to 3 so p0 wins first); otherwise fixed p0>p1>p2>p3.
module core_mem_port_arb
  import core_mem_pkg::*;
(
`ifdef CORE_MEM_RR_ARB_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             take,
`endif
  input  logic [PORTS-1:0] req,
  output logic [PORTS-1:0] gnt,
  output logic [1:0]       idx
);
`ifdef CORE_MEM_RR_ARB_EN
  logic [1:0] ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= 2'd3;
    else if (take) ptr <= idx;
  // lowest offset from ptr+1 wins, so scan the farthest first and let nearer ones overwrite
  always_comb begin
    idx = '0;
    for (int k = PORTS - 1; k >= 0; k--)
      if (req[2'(ptr + 2'(k + 1))]) idx = 2'(ptr + 2'(k + 1));
  end
`else
  always_comb begin
    idx = '0;
    for (int k = PORTS - 1; k >= 0; k--)
      if (req[k]) idx = 2'(k);
  end
`endif
  assign gnt = |req ? PORTS'(1) << idx : '0;
endmodule

// File: rtl/core_mem_port_ctl.sv
// core_mem_port_ctl: four-port arbiter and destructive-read / restore-write sequencer for one core module.
// Arbitration is fixed priority unless CORE_MEM_RR_ARB_EN is defined.
module core_mem_port_ctl
  import core_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int T_RD   = T_RD_DEF,
  parameter int T_WR   = T_WR_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PORTS-1:0]        sel_en,
  input  logic [PORTS-1:0]        rq_cyc,
  input  logic [PORTS-1:0]        rd_rq,
  input  logic [PORTS-1:0]        wr_rq,
  input  logic [PORTS*ADDR_W-1:0] ma,
  input  logic [PORTS*WORD_W-1:0] mb_wr,
  input  logic [PORTS-1:0]        wr_rs,
  output logic [PORTS-1:0]        addr_ack,
  output logic [PORTS-1:0]        rd_rs,
  output logic [WORD_W-1:0]       mb_rd,
  output logic [ADDR_W-1:0]       core_addr,
  input  logic [WORD_W-1:0]       core_rdata,
  output logic                    core_we,
  output logic [WORD_W-1:0]       core_wdata,
  output logic                    busy
);
  localparam int CW = $clog2((T_RD > T_WR ? T_RD : T_WR) + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [PORTS-1:0] elig, gnt;
  logic [1:0] gi, g;
  logic rd_l, wr_l, go, cap;
  logic [WORD_W-1:0] data_buf;
  assign elig = rq_cyc & sel_en & (rd_rq | wr_rq);
  assign go = state == S_IDLE && |elig;
  // core_addr is registered at grant, so data is T_RD cycles old one cycle before RD ends;
  // capturing there lets rd_rs land in the last RD cycle, clear of core_we
  assign cap = state == S_RD && cnt == CW'(2);
  assign core_we = state == S_WR;
  assign core_wdata = data_buf;
  assign busy = state != S_IDLE;
  core_mem_port_arb u_arb (
`ifdef CORE_MEM_RR_ARB_EN
    .clk  (clk),
    .reset(reset),
    .take (go),
`endif
    .req  (elig),
    .gnt  (gnt),
    .idx  (gi)
  );
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    case (state)
      S_IDLE: nxt = go ? S_ACK : S_IDLE;
      S_ACK: begin
        nxt = S_RD;
        cnt_n = CW'(T_RD);
      end
      S_RD: begin
        nxt = cnt == CW'(1) ? (wr_l ? S_RS_WAIT : S_WR) : S_RD;
        cnt_n = cnt == CW'(1) ? CW'(T_WR) : cnt - CW'(1);
      end
      S_RS_WAIT: nxt = (wr_rs[g] || !rq_cyc[g]) ? S_WR : S_RS_WAIT;
      S_WR: begin
        nxt = cnt == CW'(1) ? S_REST : S_WR;
        cnt_n = cnt - CW'(1);
      end
      S_REST: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      g <= '0;
      rd_l <= 1'b0;
      wr_l <= 1'b0;
      core_addr <= '0;
      data_buf <= '0;
      mb_rd <= '0;
      addr_ack <= '0;
      rd_rs <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      addr_ack <= go ? gnt : '0;
      rd_rs <= (cap && rd_l) ? PORTS'(1) << g : '0;
      if (go) begin
        g <= gi;
        core_addr <= ma[gi*ADDR_W +: ADDR_W];
        rd_l <= rd_rq[gi];
        wr_l <= wr_rq[gi];
      end
      if (cap) begin
        data_buf <= (wr_l && !rd_l) ? '0 : core_rdata;
        if (rd_l) mb_rd <= core_rdata;
      end
      if (state == S_RS_WAIT && wr_rs[g]) data_buf <= mb_wr[g*WORD_W +: WORD_W];
    end
endmodule
